regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 hardwired to zero, a post-reset clear sequencer,
// a per-register pending-write scoreboard and an optional write-to-read bypass.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            ready,
  output logic [AW:0]     pending_cnt
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_next;
  logic [AW:0]     w_cnt;
  logic            w_run;
  logic            w_wr_ok;
  logic            w_claim_ok;
  logic [1:0][AW-1:0] w_raddr;

  assign w_run      = (r_state == ST_RUN);
  assign w_wr_ok    = w_run && wr_en && (wr_addr != '0);
  assign w_claim_ok = w_run && claim_en && (claim_addr != '0);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_INIT: begin
        w_idx_next = r_idx + AW'(1);
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_idx   <= AW'(1);
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Storage is never reset directly; the INIT sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) begin
        r_regs[r_idx] <= '0;
      end else if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
      end
    end
  end

  // A claim beats a same-address write: the newer producer keeps the register pending.
  assign w_sb_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_sb
      assign w_sb_next[gi] = (w_claim_ok && (claim_addr == AW'(gi))) ? 1'b1 :
                             (w_wr_ok && (wr_addr == AW'(gi)))       ? 1'b0 :
                             r_sb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_cnt = w_cnt + {{AW{1'b0}}, r_sb[i]};
    end
  end

  assign w_raddr = {rs2_addr, rs1_addr};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] w_val;
      logic            w_busy;
      always_comb begin
        w_val  = '0;
        w_busy = 1'b0;
        if (w_run && (w_raddr[gi] != '0)) begin
          if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_raddr[gi])) begin
            // Busy shows the post-edge scoreboard: only a same-cycle claim keeps it set.
            w_val  = wr_data;
            w_busy = w_claim_ok && (claim_addr == w_raddr[gi]);
          end else begin
            w_val  = r_regs[w_raddr[gi]];
            w_busy = r_sb[w_raddr[gi]];
          end
        end
      end
    end
  endgenerate

  assign rs1_val     = g_rd[0].w_val;
  assign rs1_busy    = g_rd[0].w_busy;
  assign rs2_val     = g_rd[1].w_val;
  assign rs2_busy    = g_rd[1].w_busy;
  assign ready       = w_run;
  assign pending_cnt = w_cnt;

endmodule
